// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : PC owner, one imem read per cycle, IF/ID register, branch/bubble
// Revision    : 1.0
// ============================================================================
module instr_fetch #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] NOP_INSTR  = 16'h0800,
   parameter int          DELAY_SLOT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifi_stall,
   input  logic        ifi_branch,
   input  logic [15:0] ifi_new_pc,
   input  logic [15:0] ifi_mem_data,
   input  logic        ifi_mem_ack,
   output logic [15:0] ifo_mem_addr,
   output logic        ifo_mem_req,
   output logic [15:0] ifo_addr,
   output logic [15:0] ifo_instr,
   output logic        ifo_valid,
   output logic [15:0] ifo_pc
);

   localparam logic [0:0] c_RUN     = 1'b0;
   localparam logic [0:0] c_BR_PEND = 1'b1;
   localparam bit         c_DS      = (DELAY_SLOT != 0);

   logic [0:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] pend_q, pend_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] instr_q, instr_d;
   logic        valid_q, valid_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!ifi_stall) begin
         case (state_q)
            c_RUN: begin
               if (ifi_branch && c_DS && !ifi_mem_ack) begin
                  state_d = c_BR_PEND;
               end
            end
            c_BR_PEND: begin
               if (ifi_mem_ack) begin
                  state_d = c_RUN;
               end
            end
            default: state_d = c_RUN;
         endcase
      end
   end

   // Output / datapath logic; every non-stall cycle either issues or bubbles
   always_comb begin
      pc_d    = pc_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (!ifi_stall) begin
         addr_d  = pc_q;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         case (state_q)
            c_RUN: begin
               if (ifi_branch) begin
                  if (!c_DS) begin
                     pc_d = ifi_new_pc;
                  end else if (ifi_mem_ack) begin
                     instr_d = ifi_mem_data;
                     valid_d = 1'b1;
                     pc_d    = ifi_new_pc;
                  end else begin
                     pend_d = ifi_new_pc;
                  end
               end else if (ifi_mem_ack) begin
                  instr_d = ifi_mem_data;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 16'd1;
               end
            end
            c_BR_PEND: begin
               if (ifi_mem_ack) begin
                  instr_d = ifi_mem_data;
                  valid_d = 1'b1;
                  pc_d    = pend_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         pend_q  <= 16'h0000;
         addr_q  <= 16'h0000;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign ifo_mem_addr = pc_q;
   assign ifo_mem_req  = ~rst & ~ifi_stall;
   assign ifo_addr     = addr_q;
   assign ifo_instr    = instr_q;
   assign ifo_valid    = valid_q;
   assign ifo_pc       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Directed bench for instr_fetch; a DELAY_SLOT=1 and a DELAY_SLOT=0 instance share stimulus.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst, stall, branch, ack;
   logic [15:0] new_pc;
   logic [15:0] d1_data, d1_maddr, d1_addr, d1_instr, d1_pc;
   logic        d1_req, d1_valid;
   logic [15:0] d0_data, d0_maddr, d0_addr, d0_instr, d0_pc;
   logic        d0_req, d0_valid;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   assign d1_data = d1_maddr ^ 16'hA5A5;
   assign d0_data = d0_maddr ^ 16'hA5A5;

   instr_fetch #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800), .DELAY_SLOT(1)) u_ds1 (
      .clk(clk), .rst(rst), .ifi_stall(stall), .ifi_branch(branch), .ifi_new_pc(new_pc),
      .ifi_mem_data(d1_data), .ifi_mem_ack(ack), .ifo_mem_addr(d1_maddr), .ifo_mem_req(d1_req),
      .ifo_addr(d1_addr), .ifo_instr(d1_instr), .ifo_valid(d1_valid), .ifo_pc(d1_pc));

   instr_fetch #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800), .DELAY_SLOT(0)) u_ds0 (
      .clk(clk), .rst(rst), .ifi_stall(stall), .ifi_branch(branch), .ifi_new_pc(new_pc),
      .ifi_mem_data(d0_data), .ifi_mem_ack(ack), .ifo_mem_addr(d0_maddr), .ifo_mem_req(d0_req),
      .ifo_addr(d0_addr), .ifo_instr(d0_instr), .ifo_valid(d0_valid), .ifo_pc(d0_pc));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset_and_run(input int n);
      rst = 1'b1; stall = 1'b0; branch = 1'b0; ack = 1'b0; new_pc = 16'h0000;
      step();
      rst = 1'b0; ack = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; branch = 1'b0; ack = 1'b1; new_pc = 16'h1234;
      step(); step();
      checks++; if (d1_instr !== 16'h0800) begin failures++; $display("FAIL reset_instr got=%h exp=0800", d1_instr); end
      checks++; if (d1_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", d1_valid); end
      checks++; if (d1_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", d1_addr); end
      checks++; if (d1_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", d1_pc); end
      checks++; if (d1_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", d1_req); end
      checks++; if (d0_instr !== 16'h0800 || d0_valid !== 1'b0) begin failures++; $display("FAIL reset_ds0 got=%h/%b exp=0800/0", d0_instr, d0_valid); end
   endtask

   task automatic test_sequential();
      logic [15:0] e;
      rst = 1'b0; ack = 1'b1;
      #1;
      checks++; if (d1_req !== 1'b1) begin failures++; $display("FAIL seq_req got=%b exp=1", d1_req); end
      for (int i = 0; i < 5; i++) begin
         step();
         e = 16'(i);
         checks++; if (d1_addr !== e || d1_valid !== 1'b1 || d1_instr !== (e ^ 16'hA5A5)) begin
            failures++; $display("FAIL seq_%0d got=%h/%h/%b exp=%h/%h/1", i, d1_addr, d1_instr, d1_valid, e, e ^ 16'hA5A5);
         end
      end
      checks++; if (d1_pc !== 16'h0005) begin failures++; $display("FAIL seq_pc got=%h exp=0005", d1_pc); end
   endtask

   task automatic test_branch_ack();
      do_reset_and_run(5);
      branch = 1'b1; new_pc = 16'h0040;
      step();
      checks++; if (d1_addr !== 16'h0005 || d1_valid !== 1'b1 || d1_instr !== 16'hA5A0) begin
         failures++; $display("FAIL br_slot got=%h/%h/%b exp=0005/a5a0/1", d1_addr, d1_instr, d1_valid); end
      branch = 1'b0;
      step();
      checks++; if (d1_addr !== 16'h0040 || d1_valid !== 1'b1) begin failures++; $display("FAIL br_tgt got=%h/%b exp=0040/1", d1_addr, d1_valid); end
      step();
      checks++; if (d1_addr !== 16'h0041 || d1_instr !== 16'hA5E4) begin failures++; $display("FAIL br_tgt1 got=%h/%h exp=0041/a5e4", d1_addr, d1_instr); end
   endtask

   task automatic test_branch_pending();
      do_reset_and_run(5);
      branch = 1'b1; new_pc = 16'h0040; ack = 1'b0;
      step();
      checks++; if (d1_valid !== 1'b0 || d1_instr !== 16'h0800 || d1_pc !== 16'h0005) begin
         failures++; $display("FAIL pend_b1 got=%b/%h/%h exp=0/0800/0005", d1_valid, d1_instr, d1_pc); end
      new_pc = 16'h0099;
      step();
      checks++; if (d1_valid !== 1'b0 || d1_instr !== 16'h0800 || d1_pc !== 16'h0005) begin
         failures++; $display("FAIL pend_b2 got=%b/%h/%h exp=0/0800/0005", d1_valid, d1_instr, d1_pc); end
      branch = 1'b0; ack = 1'b1;
      step();
      checks++; if (d1_addr !== 16'h0005 || d1_valid !== 1'b1 || d1_pc !== 16'h0040) begin
         failures++; $display("FAIL pend_slot got=%h/%b/%h exp=0005/1/0040", d1_addr, d1_valid, d1_pc); end
      step();
      checks++; if (d1_addr !== 16'h0040 || d1_valid !== 1'b1) begin failures++; $display("FAIL pend_tgt got=%h/%b exp=0040/1", d1_addr, d1_valid); end
   endtask

   task automatic test_stall();
      do_reset_and_run(5);
      stall = 1'b1; branch = 1'b1; new_pc = 16'h0040; ack = 1'b1;
      #1;
      checks++; if (d1_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", d1_req); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (d1_pc !== 16'h0005 || d1_addr !== 16'h0004 || d1_instr !== 16'hA5A1 || d1_valid !== 1'b1) begin
            failures++; $display("FAIL stall_hold%0d got=%h/%h/%h/%b exp=0005/0004/a5a1/1", i, d1_pc, d1_addr, d1_instr, d1_valid); end
      end
      stall = 1'b0;
      step();
      checks++; if (d1_addr !== 16'h0005 || d1_valid !== 1'b1 || d1_pc !== 16'h0040) begin
         failures++; $display("FAIL stall_slot got=%h/%b/%h exp=0005/1/0040", d1_addr, d1_valid, d1_pc); end
      branch = 1'b0;
      step();
      checks++; if (d1_addr !== 16'h0040) begin failures++; $display("FAIL stall_tgt got=%h exp=0040", d1_addr); end
   endtask

   task automatic test_wrap();
      do_reset_and_run(0);
      branch = 1'b1; new_pc = 16'hFFFF;
      step();
      branch = 1'b0;
      step();
      checks++; if (d1_addr !== 16'hFFFF || d1_instr !== 16'h5A5A || d1_pc !== 16'h0000) begin
         failures++; $display("FAIL wrap got=%h/%h/%h exp=ffff/5a5a/0000", d1_addr, d1_instr, d1_pc); end
      step();
      checks++; if (d1_addr !== 16'h0000 || d1_valid !== 1'b1) begin failures++; $display("FAIL wrap_next got=%h/%b exp=0000/1", d1_addr, d1_valid); end
   endtask

   task automatic test_reset_in_pend();
      do_reset_and_run(5);
      branch = 1'b1; new_pc = 16'h0040; ack = 1'b0;
      step();
      branch = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; ack = 1'b1;
      step();
      checks++; if (d1_addr !== 16'h0000 || d1_pc !== 16'h0001) begin failures++; $display("FAIL rstpend got=%h/%h exp=0000/0001", d1_addr, d1_pc); end
      step();
      checks++; if (d1_addr !== 16'h0001) begin failures++; $display("FAIL rstpend_next got=%h exp=0001", d1_addr); end
   endtask

   task automatic test_no_delay_slot();
      do_reset_and_run(5);
      branch = 1'b1; new_pc = 16'h0010; ack = 1'b1;
      step();
      checks++; if (d0_valid !== 1'b0 || d0_instr !== 16'h0800 || d0_pc !== 16'h0010) begin
         failures++; $display("FAIL nods_bubble got=%b/%h/%h exp=0/0800/0010", d0_valid, d0_instr, d0_pc); end
      branch = 1'b0;
      step();
      checks++; if (d0_addr !== 16'h0010 || d0_valid !== 1'b1 || d0_instr !== 16'hA5B5) begin
         failures++; $display("FAIL nods_tgt got=%h/%b/%h exp=0010/1/a5b5", d0_addr, d0_valid, d0_instr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch_ack();
      test_branch_pending();
      test_stall();
      test_wrap();
      test_reset_in_pend();
      test_no_delay_slot();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. Owns the PC and issues one instruction-memory read per cycle. Registers the fetched address/instruction pair into the decode inputs. Redirects the PC on the decode-stage branch outputs, honouring one architectural delay slot, and inserts NOP bubbles when memory is busy.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding driven on bubbles (opcode5 = NOP)
DELAY_SLOT, 1, 1 = instruction after a branch executes; 0 = it is squashed to NOP

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
ifi_stall  input  1  hazard stall from downstream; hold PC, state and outputs
ifi_branch  input  1  branch taken, from decode stage
ifi_new_pc  input  16  branch target, from decode stage
ifi_mem_data  input  16  instruction word, valid when ifi_mem_ack=1
ifi_mem_ack  input  1  memory served this cycle's request (same-cycle data)
ifo_mem_addr  output  16  fetch address (= pc, combinational)
ifo_mem_req  output  1  fetch request (= ~rst & ~ifi_stall, combinational)
ifo_addr  output  16  registered address of ifo_instr, feeds decode address input
ifo_instr  output  16  registered instruction, feeds decode instruction input
ifo_valid  output  1  1 = ifo_instr is a real fetched instruction, 0 = bubble
ifo_pc  output  16  current PC register (debug/trace)

Behaviour:
- State: pc[15:0], pend_target[15:0], FSM {RUN, BR_PEND}, output regs addr/instr/valid.
- Reset (sync, highest priority): pc<=RESET_PC, state<=RUN, pend_target<=0, ifo_addr<=0, ifo_instr<=NOP_INSTR, ifo_valid<=0.
- Latency: instruction acked in cycle N appears on ifo_instr in cycle N+1.
- Priority per edge (not reset): stall > branch > ack > bubble.
- ifi_stall=1: pc, state, pend_target, ifo_* all hold; ifi_branch and ifi_mem_ack ignored.
- RUN, ifi_branch=1:
  - DELAY_SLOT=1, ack=1: ifo_addr<=pc, ifo_instr<=ifi_mem_data, ifo_valid<=1, pc<=ifi_new_pc.
  - DELAY_SLOT=1, ack=0: bubble out, pc holds, pend_target<=ifi_new_pc, state<=BR_PEND.
  - DELAY_SLOT=0: bubble out, pc<=ifi_new_pc regardless of ack.
- RUN, no branch, ack=1: ifo_addr<=pc, ifo_instr<=ifi_mem_data, ifo_valid<=1, pc<=pc+1.
- RUN, no branch, ack=0: bubble.
- BR_PEND, ifi_branch ignored:
  - ack=1: delay slot issued (ifo_addr<=pc, instr<=data, valid<=1), pc<=pend_target, state<=RUN.
  - ack=0: bubble, remain.
- Bubble: ifo_instr<=NOP_INSTR, ifo_valid<=0, ifo_addr<=pc.
- PC arithmetic: 16-bit word address, pc+1 wraps 16'hFFFF -> 16'h0000. Branch target taken verbatim.
- Reset mid-BR_PEND discards the pending target.

Test Plan:
- Reset then ack=1 every cycle, mem returns addr^16'hA5A5 -> ifo_addr 0,1,2,... one cycle after request, ifo_valid=1; during reset ifo_instr=16'h0800, ifo_valid=0, ifo_mem_req=0.
- At pc=5 assert ifi_branch, ifi_new_pc=16'h0040, ack=1 -> next ifo_addr=5 (delay slot, valid=1), then ifo_addr=16'h0040, 16'h0041.
- Same, but ack=0 for 2 cycles at branch -> two bubbles (valid=0, instr=16'h0800), state BR_PEND. Ack returns -> ifo_addr=5, then 16'h0040.
- ifi_stall=1 for 3 cycles while ifi_branch=1 and ack=1 -> pc, ifo_* unchanged, ifo_mem_req=0. Stall drops -> branch handled as in second test.
- pc=16'hFFFF, ack=1, no branch -> ifo_addr=16'hFFFF, then pc=16'h0000.
- DELAY_SLOT=0, branch at pc=5 to 16'h0010 with ack=1 -> bubble (valid=0), then ifo_addr=16'h0010.
